// File: rtl/tft_bus_sequencer.sv
// 8080-style write-only bus sequencer for a TFT panel controller.
// After reset it pulses RESX, waits for the panel to wake, and plays a small
// init ROM. It then fills rectangular windows: CASET/PASET/RAMWR followed by
// a stream of RGB565 pixels taken from a valid/ready source, two bytes each.

`timescale 1ns/1ps

module tft_bus_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int RST_CYCLES = 1000,
    parameter int RST_WAIT   = 120000,
    parameter int DELAY_UNIT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] y0,
    input  logic [15:0] y1,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic        busy,
    output logic        init_done,
    output logic        err,
    output logic [7:0]  lcd_data,
    output logic        lcd_csx,
    output logic        lcd_resx,
    output logic        lcd_dcx,
    output logic        lcd_wrx,
    output logic        lcd_rdx
);

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT_FETCH,
        ST_INIT_WRITE,
        ST_INIT_DELAY,
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_PIXEL_HI,
        ST_PIXEL_LO,
        ST_FINISH
    } state_t;

    // ROM entry kinds; bit 0 of a byte kind doubles as the DCX level.
    typedef enum logic [1:0] {
        K_CMD = 2'b00,
        K_DAT = 2'b01,
        K_DLY = 2'b10,
        K_END = 2'b11
    } kind_t;

    localparam int          PH_W    = $clog2(2 * CLK_DIV + 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV);
    localparam logic [31:0] RST_LOW_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT - 1);
    localparam logic [31:0] DELAY_MULT    = 32'(DELAY_UNIT);
    localparam logic [3:0]  SEQ_DONE      = 4'd11;

    state_t          state;
    logic [31:0]     cnt;        // shared by reset-low, reset-wait and ROM delays
    logic [7:0]      rom_idx;
    logic [7:0]      dly_val;
    logic [PH_W-1:0] ph;         // cycles the current byte has been on the bus
    logic            on_bus;
    logic [3:0]      seq;        // byte index across CASET/PASET/RAMWR
    logic [31:0]     pix_cnt;
    logic [7:0]      lo_byte;
    logic [15:0]     win_x0, win_x1, win_y0, win_y1;
    logic [9:0]      entry;
    logic            byte_end;

    // NOTE: the init ROM is a constant case table, so it is pure logic with
    // nothing to reset; only the index that addresses it is a register.
    function automatic logic [9:0] rom_entry(input logic [7:0] idx);
        case (idx)
            8'd0:    rom_entry = {K_CMD, 8'h01};
            8'd1:    rom_entry = {K_DLY, 8'd1};
            8'd2:    rom_entry = {K_CMD, 8'h11};
            8'd3:    rom_entry = {K_DAT, 8'h55};
            default: rom_entry = {K_END, 8'h00};
        endcase
    endfunction

    // Window-setup byte stream as {dcx, data}: 2A x0 x1, 2B y0 y1, 2C.
    function automatic logic [8:0] seq_byte(input logic [3:0] s,
                                            input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] b0, input logic [15:0] b1);
        case (s)
            4'd0:    seq_byte = {1'b0, 8'h2A};
            4'd1:    seq_byte = {1'b1, a0[15:8]};
            4'd2:    seq_byte = {1'b1, a0[7:0]};
            4'd3:    seq_byte = {1'b1, a1[15:8]};
            4'd4:    seq_byte = {1'b1, a1[7:0]};
            4'd5:    seq_byte = {1'b0, 8'h2B};
            4'd6:    seq_byte = {1'b1, b0[15:8]};
            4'd7:    seq_byte = {1'b1, b0[7:0]};
            4'd8:    seq_byte = {1'b1, b1[15:8]};
            4'd9:    seq_byte = {1'b1, b1[7:0]};
            default: seq_byte = {1'b0, 8'h2C};
        endcase
    endfunction

    // Put a byte on the bus: data and DCX held for the whole byte, WRX low first.
    task automatic send_byte(input logic [8:0] b);
        {lcd_dcx, lcd_data} <= b;
        lcd_wrx             <= 1'b0;
        on_bus              <= 1'b1;
        ph                  <= PH_ONE;
    endtask

    assign entry    = rom_entry(rom_idx);
    assign byte_end = on_bus && (ph == PH_LAST);
    assign lcd_rdx  = 1'b1;

    // The source may hand over a pixel only while the FSM is parked waiting for one.
    assign px_ready = (state == ST_PIXEL_HI) && !on_bus && px_valid;

    // Sequencer FSM together with the byte-timing engine and all registered outputs.
    // NOTE: every register here is assigned with <= so all reads in this block
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_RST_LOW;
            cnt       <= '0;
            rom_idx   <= '0;
            dly_val   <= '0;
            ph        <= '0;
            on_bus    <= 1'b0;
            seq       <= '0;
            pix_cnt   <= '0;
            lo_byte   <= '0;
            win_x0    <= '0;
            win_x1    <= '0;
            win_y0    <= '0;
            win_y1    <= '0;
            lcd_resx  <= 1'b0;
            lcd_csx   <= 1'b1;
            lcd_wrx   <= 1'b1;
            lcd_dcx   <= 1'b1;
            lcd_data  <= 8'h00;
            busy      <= 1'b1;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;

            // Byte timing: WRX low for CLK_DIV cycles, high for CLK_DIV cycles.
            // A launch issued by the state logic below overrides the release.
            if (on_bus) begin
                if (ph == PH_LAST) begin
                    on_bus <= 1'b0;
                end else begin
                    ph <= ph + PH_ONE;
                    if (ph == PH_HALF) lcd_wrx <= 1'b1;
                end
            end

            case (state)
                ST_RST_LOW: begin
                    if (cnt == RST_LOW_LAST) begin
                        cnt      <= '0;
                        lcd_resx <= 1'b1;
                        state    <= ST_RST_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_RST_WAIT: begin
                    if (cnt == RST_WAIT_LAST) begin
                        cnt     <= '0;
                        rom_idx <= '0;
                        lcd_csx <= 1'b0;   // select the panel ahead of the first init byte
                        state   <= ST_INIT_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_INIT_FETCH: begin
                    rom_idx <= rom_idx + 8'd1;
                    case (kind_t'(entry[9:8]))
                        K_CMD, K_DAT: begin
                            send_byte({entry[8], entry[7:0]});
                            state <= ST_INIT_WRITE;
                        end
                        K_DLY: begin
                            // A zero delay costs only this fetch cycle.
                            if (entry[7:0] != 8'd0) begin
                                dly_val <= entry[7:0];
                                cnt     <= '0;
                                state   <= ST_INIT_DELAY;
                            end
                        end
                        default: begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            lcd_csx   <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    endcase
                end

                ST_INIT_WRITE: begin
                    if (byte_end) state <= ST_INIT_FETCH;
                end

                ST_INIT_DELAY: begin
                    if (cnt == 32'(dly_val) * DELAY_MULT - 32'd1) begin
                        state <= ST_INIT_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_IDLE: begin
                    if (start) begin
                        if (x0 <= x1 && y0 <= y1) begin
                            win_x0  <= x0;
                            win_x1  <= x1;
                            win_y0  <= y0;
                            win_y1  <= y1;
                            // A full 65536 x 65536 window wraps to 0, which the
                            // decrement-then-compare loop treats as 2^32 pixels.
                            pix_cnt <= (32'(x1) - 32'(x0) + 32'd1) * (32'(y1) - 32'(y0) + 32'd1);
                            seq     <= '0;
                            lcd_csx <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_CASET;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_CASET, ST_PASET, ST_RAMWR: begin
                    if (!on_bus || byte_end) begin
                        if (seq == SEQ_DONE) begin
                            state <= ST_PIXEL_HI;
                        end else begin
                            send_byte(seq_byte(seq, win_x0, win_x1, win_y0, win_y1));
                            seq   <= seq + 4'd1;
                            state <= (seq < 4'd5)  ? ST_CASET :
                                     (seq < 4'd10) ? ST_PASET : ST_RAMWR;
                        end
                    end
                end

                ST_PIXEL_HI: begin
                    // Idle with WRX high and CSX low for as long as the source stalls.
                    if (!on_bus) begin
                        if (px_valid) begin
                            lo_byte <= px_data[7:0];
                            send_byte({1'b1, px_data[15:8]});
                        end
                    end else if (byte_end) begin
                        send_byte({1'b1, lo_byte});
                        state <= ST_PIXEL_LO;
                    end
                end

                ST_PIXEL_LO: begin
                    if (byte_end) begin
                        pix_cnt <= pix_cnt - 32'd1;
                        if (pix_cnt == 32'd1) begin
                            lcd_csx <= 1'b1;
                            state   <= ST_FINISH;
                        end else begin
                            state <= ST_PIXEL_HI;
                        end
                    end
                end

                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_tft_bus_sequencer.sv
// Scoreboard bench for tft_bus_sequencer: directed stimulus pushes the expected
// {dcx, data} bytes into a queue; a bus monitor pops and compares on every
// WRX rising edge. Covers power-up init, window fills, rejected and ignored
// starts, a source stall and a reset in the middle of a fill.

`timescale 1ns/1ps

module tb_tft_bus_sequencer;

    localparam int CLK_DIV    = 2;
    localparam int RST_CYCLES = 4;
    localparam int RST_WAIT   = 8;
    localparam int DELAY_UNIT = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x0, x1, y0, y1;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready, busy, init_done, err;
    logic [7:0]  lcd_data;
    logic        lcd_csx, lcd_resx, lcd_dcx, lcd_wrx, lcd_rdx;

    tft_bus_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES),
        .RST_WAIT   (RST_WAIT),
        .DELAY_UNIT (DELAY_UNIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .busy      (busy),
        .init_done (init_done),
        .err       (err),
        .lcd_data  (lcd_data),
        .lcd_csx   (lcd_csx),
        .lcd_resx  (lcd_resx),
        .lcd_dcx   (lcd_dcx),
        .lcd_wrx   (lcd_wrx),
        .lcd_rdx   (lcd_rdx)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  exp_q[$];     // expected bus bytes as {dcx, data}
    int          fall_cyc[$];  // cycle stamps of WRX falling edges
    logic [15:0] px_q[$];      // pixels offered by the source model
    bit          px_hold  = 1'b0;
    int          ready_cnt = 0;
    int          err_cnt   = 0;
    int          cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: pops one expected byte per WRX rising edge while out of reset.
    initial begin : bus_monitor
        logic prev_wrx;
        int   low_run;
        logic [8:0] e;
        prev_wrx = 1'b1;
        low_run  = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                prev_wrx = 1'b1;
                low_run  = 0;
            end else begin
                if (prev_wrx && !lcd_wrx) fall_cyc.push_back(cyc);
                if (!lcd_wrx) begin
                    low_run++;
                end else if (!prev_wrx) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected byte: got dcx=%0b data=0x%0h, expected no bus activity",
                                 lcd_dcx, lcd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus byte {dcx,data}", {23'd0, lcd_dcx, lcd_data}, {23'd0, e});
                        check("wrx low cycles", low_run, CLK_DIV);
                        check("csx during byte", {31'd0, lcd_csx}, 32'd0);
                    end
                    low_run = 0;
                end
                prev_wrx = lcd_wrx;
            end
        end
    end

    // Pixel source: presents the queue head, pops when the DUT takes it.
    initial begin : px_source
        px_valid = 1'b0;
        px_data  = 16'h0000;
        forever begin
            @(negedge clock);
            px_valid = !px_hold && (px_q.size() > 0);
            px_data  = (px_q.size() > 0) ? px_q[0] : 16'h0000;
            #1;
            if (px_ready && px_valid) begin
                ready_cnt++;
                void'(px_q.pop_front());
            end
        end
    end

    initial begin : err_monitor
        forever begin
            @(negedge clock);
            if (err) err_cnt++;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] b0, input logic [15:0] b1);
        @(negedge clock);
        x0 = a0; x1 = a1; y0 = b0; y1 = b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic push_header(input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] b0, input logic [15:0] b1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, a0[15:8]}); exp_q.push_back({1'b1, a0[7:0]});
        exp_q.push_back({1'b1, a1[15:8]}); exp_q.push_back({1'b1, a1[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, b0[15:8]}); exp_q.push_back({1'b1, b0[7:0]});
        exp_q.push_back({1'b1, b1[15:8]}); exp_q.push_back({1'b1, b1[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
    endtask

    task automatic push_pixel(input logic [15:0] p);
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h55});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " resx"},      {31'd0, lcd_resx},  32'd0);
        check({tag, " csx"},       {31'd0, lcd_csx},   32'd1);
        check({tag, " wrx"},       {31'd0, lcd_wrx},   32'd1);
        check({tag, " rdx"},       {31'd0, lcd_rdx},   32'd1);
        check({tag, " dcx"},       {31'd0, lcd_dcx},   32'd1);
        check({tag, " data"},      {24'd0, lcd_data},  32'd0);
        check({tag, " px_ready"},  {31'd0, px_ready},  32'd0);
        check({tag, " busy"},      {31'd0, busy},      32'd1);
        check({tag, " init_done"}, {31'd0, init_done}, 32'd0);
        check({tag, " err"},       {31'd0, err},       32'd0);
    endtask

    // Called at the negedge where reset is released.
    task automatic check_power_up();
        int n;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!lcd_resx && n < 100);
        check("resx low cycles", n, RST_CYCLES);
        // RST_WAIT idle cycles plus the fetch of the first ROM entry.
        n = 0;
        do begin @(posedge clock); #1; n++; end while (lcd_wrx && n < 100);
        check("cycles from resx release to first byte", n, RST_WAIT + 1);
    endtask

    task automatic wait_init_done();
        int n;
        n = 0;
        while (!init_done && n < 5000) begin @(negedge clock); n++; end
        check("init_done after init", {31'd0, init_done}, 32'd1);
        check("busy after init",      {31'd0, busy},      32'd0);
        check("csx after init",       {31'd0, lcd_csx},   32'd1);
        check("init bytes all seen",  exp_q.size(),       32'd0);
    endtask

    task automatic wait_fill_done(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin @(negedge clock); n++; end
        check({tag, " busy falls"},      {31'd0, busy},    32'd0);
        check({tag, " csx after fill"},  {31'd0, lcd_csx}, 32'd1);
        check({tag, " all bytes seen"},  exp_q.size(),     32'd0);
    endtask

    initial begin : stimulus
        logic [8:0] t1_bytes[15];
        int n, viol, base;

        t1_bytes = '{9'h02A, 9'h100, 9'h110, 9'h100, 9'h111,
                     9'h02B, 9'h100, 9'h120, 9'h100, 9'h120,
                     9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0};

        reset = 1'b0;
        start = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");

        // Power-up init, with a start pulse during the ROM delay that must be ignored.
        push_init();
        reset = 1'b1;
        check_power_up();
        repeat (200) @(negedge clock);
        do_start(16'd0, 16'd0, 16'd0, 16'd0);
        wait_init_done();
        // One fetch cycle after the first byte, DELAY_UNIT delay cycles, one fetch.
        if (fall_cyc.size() >= 2)
            check("init delay gap between byte starts", fall_cyc[1] - fall_cyc[0],
                  2 * CLK_DIV + DELAY_UNIT + 2);
        else
            check("init byte starts recorded", fall_cyc.size(), 32'd3);

        // 2x1 fill with the exact byte list; a second start mid-fill is ignored.
        foreach (t1_bytes[i]) exp_q.push_back(t1_bytes[i]);
        px_q.push_back(16'hF800);
        px_q.push_back(16'h07E0);
        do_start(16'h0010, 16'h0011, 16'h0020, 16'h0020);
        check("busy after accepted start", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clock);
        do_start(16'h0000, 16'h0001, 16'h0000, 16'h0001);
        wait_fill_done("2x1 fill");
        check("px_ready pulses after 2x1 fill", ready_cnt, 32'd2);

        // Inverted window is rejected with a single err pulse.
        do_start(16'd5, 16'd4, 16'd0, 16'd0);
        check("err on rejected start", {31'd0, err}, 32'd1);
        @(negedge clock);
        check("err one cycle only", {31'd0, err}, 32'd0);
        check("busy after reject",  {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clock);
        check("no bytes after reject", exp_q.size(), 32'd0);

        // 1x1 fill with the source stalled for 20 cycles after RAMWR.
        push_header(16'd3, 16'd3, 16'd7, 16'd7);
        push_pixel(16'hABCD);
        px_hold = 1'b1;
        px_q.push_back(16'hABCD);
        do_start(16'd3, 16'd3, 16'd7, 16'd7);
        n = 0;
        while (exp_q.size() > 2 && n < 500) begin @(negedge clock); n++; end
        check("header sent before stall", exp_q.size(), 32'd2);
        viol = 0;
        repeat (20) begin
            @(negedge clock);
            if (lcd_wrx !== 1'b1 || lcd_csx !== 1'b0 || px_ready !== 1'b0) viol++;
        end
        check("bus quiet during stall", viol, 32'd0);
        px_hold = 1'b0;
        wait_fill_done("1x1 fill");
        check("px_ready pulses after 1x1 fill", ready_cnt, 32'd3);

        // 4x4 fill aborted by reset while the third pixel's high byte is on the bus.
        base = ready_cnt;
        push_header(16'd0, 16'd3, 16'd0, 16'd3);
        push_pixel(16'h1000);
        push_pixel(16'h1001);
        for (int i = 0; i < 16; i++) px_q.push_back(16'h1000 + 16'(i));
        do_start(16'd0, 16'd3, 16'd0, 16'd3);
        n = 0;
        while (ready_cnt < base + 3 && n < 2000) begin @(negedge clock); n++; end
        check("third pixel taken", ready_cnt, base + 3);
        check("wrx low before abort", {31'd0, lcd_wrx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid-fill reset");
        check("no pending bytes at abort", exp_q.size(), 32'd0);
        push_init();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check_power_up();
        wait_init_done();
        repeat (20) @(negedge clock);
        check("no pixels consumed after abort", ready_cnt, base + 3);

        px_hold = 1'b1;
        check("err pulses total", err_cnt, 32'd1);
        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
